// File: rtl/pipeline_exmem_if.sv
// ----------------------------------------------------------------------------
// pipeline_exmem_if
// Data-memory request/response bundle between the EX/MEM latch and the cache.
//   dREN, dWEN  : read / write request strobes (master -> slave)
//   dmemaddr    : access address               (master -> slave)
//   dmemstore   : store data                   (master -> slave)
//   dhit        : access completes this cycle  (slave -> master)
//   dmemload    : read data                    (slave -> master)
// ----------------------------------------------------------------------------
interface pipeline_exmem_if #(
    parameter int unsigned WORD_W = 32
);
    logic              dREN;
    logic              dWEN;
    logic [WORD_W-1:0] dmemaddr;
    logic [WORD_W-1:0] dmemstore;
    logic              dhit;
    logic [WORD_W-1:0] dmemload;

    modport master (
        output dREN,
        output dWEN,
        output dmemaddr,
        output dmemstore,
        input  dhit,
        input  dmemload
    );

    modport slave (
        input  dREN,
        input  dWEN,
        input  dmemaddr,
        input  dmemstore,
        output dhit,
        output dmemload
    );
endinterface

// File: rtl/pipeline_exmem.sv
// ----------------------------------------------------------------------------
// pipeline_exmem
// EX/MEM pipeline latch for the five-stage MIPS datapath. Latches EX results
// and control, runs the data-memory handshake (holds the request until dhit,
// freezing upstream meanwhile) and captures load data for MEM/WB.
//   CLK, nRST       : clock, asynchronous active-low reset
//   sRST, en        : synchronous flush, latch enable from hazard unit
//   wsel..extimm    : EX-stage control and data to latch
//   dmem (master)   : cache request/response bundle
//   *_l             : latched fields, dmemload_l = captured load data
//   mem_stall       : upstream freeze while a memory access is outstanding
//   halt            : sticky halt, set once any pending store has drained
//   stall_cnt       : saturating count of cycles mem_stall was high
// ----------------------------------------------------------------------------
module pipeline_exmem #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              sRST,
    input  logic              en,
    input  logic [REG_W-1:0]  wsel,
    input  logic              regen,
    input  logic [1:0]        regsrc,
    input  logic              hlt,
    input  logic              dmemREN,
    input  logic              dmemWEN,
    input  logic [WORD_W-1:0] aluout,
    input  logic [WORD_W-1:0] rdat2,
    input  logic [WORD_W-1:0] rtnaddr,
    input  logic [WORD_W-1:0] extimm,
    pipeline_exmem_if.master  dmem,
    output logic [REG_W-1:0]  wsel_l,
    output logic              regen_l,
    output logic [1:0]        regsrc_l,
    output logic              hlt_l,
    output logic [WORD_W-1:0] aluout_l,
    output logic [WORD_W-1:0] rtnaddr_l,
    output logic [WORD_W-1:0] extimm_l,
    output logic [WORD_W-1:0] dmemload_l,
    output logic              mem_stall,
    output logic              halt,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state;
    logic              ren_l;
    logic              wen_l;
    logic [WORD_W-1:0] rdat2_l;

    logic busy;
    logic is_load;
    logic accept;
    logic load_hit;

    always_comb begin
        busy      = (state == StBusy);
        // A store wins if both strobes were latched.
        is_load   = ren_l && !wen_l;
        mem_stall = busy && !dmem.dhit;
        accept    = en && !mem_stall;
        load_hit  = busy && dmem.dhit && is_load;

        dmem.dREN      = busy && is_load && !halt;
        dmem.dWEN      = busy && wen_l && !halt;
        dmem.dmemaddr  = aluout_l;
        dmem.dmemstore = rdat2_l;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= StIdle;
            wsel_l     <= '0;
            regen_l    <= 1'b0;
            regsrc_l   <= '0;
            hlt_l      <= 1'b0;
            ren_l      <= 1'b0;
            wen_l      <= 1'b0;
            aluout_l   <= '0;
            rdat2_l    <= '0;
            rtnaddr_l  <= '0;
            extimm_l   <= '0;
            dmemload_l <= '0;
            halt       <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            // Counter and halt are independent of flush/accept.
            if (mem_stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (hlt_l && !busy) begin
                halt <= 1'b1;
            end

            if (sRST) begin
                state      <= StIdle;
                wsel_l     <= '0;
                regen_l    <= 1'b0;
                regsrc_l   <= '0;
                hlt_l      <= 1'b0;
                ren_l      <= 1'b0;
                wen_l      <= 1'b0;
                aluout_l   <= '0;
                rdat2_l    <= '0;
                rtnaddr_l  <= '0;
                extimm_l   <= '0;
                dmemload_l <= '0;
            end else if (accept) begin
                wsel_l     <= wsel;
                regen_l    <= regen;
                regsrc_l   <= regsrc;
                hlt_l      <= hlt;
                ren_l      <= dmemREN;
                wen_l      <= dmemWEN;
                aluout_l   <= aluout;
                rdat2_l    <= rdat2;
                rtnaddr_l  <= rtnaddr;
                extimm_l   <= extimm;
                // A load finishing on the same edge as the accept keeps its data.
                dmemload_l <= load_hit ? dmem.dmemload : '0;
                state      <= (dmemREN || dmemWEN) ? StBusy : StIdle;
            end else if (busy && dmem.dhit) begin
                if (is_load) begin
                    dmemload_l <= dmem.dmemload;
                end
                state <= StDone;
            end
        end
    end

endmodule

// File: doc/pipeline_exmem.md
Name: pipeline_exmem

Overview:
- EX/MEM pipeline register for the five-stage MIPS datapath.
- Latches EX-stage results and control, fed directly by the ID/EX latch outputs through the ALU.
- Owns the data-memory request handshake: holds dmemREN/dmemWEN to the cache until dhit, stalls upstream meanwhile, and captures load data for MEM/WB.
- Synchronous flush (sRST) and enable (en) semantics match the other pipeline latches.

Parameters:
- WORD_W, 32, datapath word width.
- REG_W, 5, register select width.
- CNT_W, 16, width of the memory-stall performance counter.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- nRST  in  1  asynchronous, active-low reset.
- sRST  in  1  synchronous flush (bubble insert).
- en  in  1  latch enable from hazard unit.
- wsel  in  REG_W  destination register.
- regen  in  1  register write enable.
- regsrc  in  2  writeback source select.
- hlt  in  1  halt instruction.
- dmemREN  in  1  instruction is a load.
- dmemWEN  in  1  instruction is a store.
- aluout  in  WORD_W  ALU result / memory address.
- rdat2  in  WORD_W  store data (already forwarded).
- rtnaddr  in  WORD_W  PC+4 for jal.
- extimm  in  WORD_W  extended immediate (lui path).
- dhit  in  1  cache access complete this cycle.
- dmemload  in  WORD_W  cache read data.
- wsel_l, regen_l, regsrc_l, hlt_l  out  as inputs  latched control.
- aluout_l, rtnaddr_l, extimm_l  out  WORD_W  latched data.
- dmemload_l  out  WORD_W  captured load data.
- dmemaddr  out  WORD_W  = aluout_l.
- dmemstore  out  WORD_W  = latched rdat2.
- dREN, dWEN  out  1  request strobes to cache.
- mem_stall  out  1  upstream freeze request.
- halt  out  1  sticky halt.
- stall_cnt  out  CNT_W  total cycles mem_stall was high.

Behaviour:
- nRST low: all latched outputs, dmemload_l, halt and stall_cnt = 0; state = IDLE. Async, overrides everything.
- Priority at posedge: sRST > accept (en with mem_stall low) > hold.
- sRST:
  - Clears all latched fields to 0 and aborts any request (state -> IDLE, dREN/dWEN low next cycle).
  - dmemload_l cleared.
  - halt and stall_cnt unaffected.
- Accept:
  - Load every input into its _l register.
  - If dmemREN or dmemWEN is set: state -> BUSY. Otherwise state -> IDLE.
  - dmemload_l is cleared on accept.
- en while mem_stall high: ignored; registers hold. This is internal protection even if the hazard unit misbehaves.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: no request; dREN = dWEN = 0.
  - BUSY: dREN = latched dmemREN, dWEN = latched dmemWEN; mem_stall = ~dhit (combinational).
  - BUSY with dhit: capture dmemload into dmemload_l if the access is a load; state -> DONE.
  - DONE: strobes low, mem_stall = 0; hold until the next accept or sRST.
- Same-cycle dhit in BUSY plus en: the accept is legal (mem_stall is low) and the load capture and new latch happen at the same edge. The new instruction's latched op decides the next state (BUSY or IDLE); dmemload_l takes dmemload, not 0.
- Simultaneous dREN and dWEN latched: illegal. dWEN wins, dREN is forced low.
- halt:
  - Sets when hlt_l = 1 and state != BUSY (any prior store has drained).
  - Sticky until nRST; sRST does not clear it.
  - Once halt is set, dREN and dWEN are forced 0.
- stall_cnt increments each cycle mem_stall = 1 and saturates at all-ones (no wrap).
- Latency: inputs appear on _l outputs 1 cycle after accept. A memory op adds N cycles, where N is the number of cycles until dhit (N = 0 if dhit arrives in the first BUSY cycle).

Test Plan:
- Reset: assert nRST=0 mid-BUSY with dREN=1 -> next cycle all outputs 0, dREN=0, mem_stall=0, stall_cnt=0.
- Non-mem op: en=1, aluout=0x0000_0010, wsel=5, regen=1 -> after 1 edge, aluout_l=0x10, wsel_l=5, state IDLE, mem_stall=0.
- Load, 3-cycle miss: accept lw with aluout=0x0000_0100, dhit on the 3rd BUSY cycle with dmemload=0xDEADBEEF.
  - mem_stall=1 for 2 cycles and dREN held for 3.
  - dmemload_l=0xDEADBEEF; stall_cnt=2; en pulses during the stall are ignored.
- Store, immediate hit: dmemWEN=1, rdat2=0x1234_5678, dhit in the first BUSY cycle -> dWEN high 1 cycle, dmemstore=0x12345678, mem_stall never high, stall_cnt unchanged.
- Flush during BUSY: sRST=1 while dREN=1 and dhit=0 -> next cycle dREN=0, all _l fields 0, state IDLE; a later dhit is ignored.
- Halt after store: accept sw and then hlt, with dhit after 2 cycles -> halt rises only after DONE, stays 1 through sRST, and dWEN=0 thereafter.
